// File: rtl/sisc_pkg.sv
// Shared constants and encodings for the data-memory arbiter.
// The port-id constants name the two requesters so the RTL can refer to them by role.
package sisc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } own_state_e;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_LDR = 1'b1;

endpackage

// File: rtl/dm_arb_if.sv
// Requester/memory-side bundle of the data-memory arbiter.
// The master modport is the requester/memory side; the slave modport is the arbiter.
interface dm_arb_if #(
  parameter int AW = 16,
  parameter int DW = 32
);
  logic          req0, req1;
  logic          we0, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1;
  logic          rvalid;
  logic          rid;
  logic [DW-1:0] rdata;
  logic          cpu_stall;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic          dm_we;
  logic [DW-1:0] dm_rdata;

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, dm_rdata,
    input  gnt0, gnt1, rvalid, rid, rdata, cpu_stall, dm_addr, dm_wdata, dm_we
  );

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, dm_rdata,
    output gnt0, gnt1, rvalid, rid, rdata, cpu_stall, dm_addr, dm_wdata, dm_we
  );
endinterface

// File: rtl/rr_pick2.sv
// Two-way round-robin pick: a lone requester wins, and ptr breaks a tie.
module rr_pick2 (
  input  logic req0,
  input  logic req1,
  input  logic ptr,
  output logic win,
  output logic any
);
  import sisc_pkg::*;

  assign win = (req0 & req1) ? ptr : (req1 ? PORT_LDR : PORT_CPU);
  assign any = req0 | req1;
endmodule

// File: rtl/dm_arb.sv
// Two-port data-memory arbiter: owner FSM with a bounded burst under contention,
// pass-through memory port and a 1-cycle registered read return.
module dm_arb #(
  parameter int AW        = 16,
  parameter int DW        = 32,
  parameter int MAX_BURST = 4
) (
  input  logic     clk,
  input  logic     rst_f,
  dm_arb_if.slave  bus
);
  import sisc_pkg::*;

  localparam int            BW         = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);

  own_state_e    state_q;
  logic [BW-1:0] burst_q;
  logic          ptr_q;
  logic          rvalid_q;
  logic          rid_q;
  logic [DW-1:0] rdata_q;

  logic          pick_win, pick_any;
  logic          gnt0_s, gnt1_s;
  logic          own_id, own_req, oth_req;
  logic          rd_fire;
  logic [AW-1:0] dm_addr_s;
  logic [DW-1:0] dm_wdata_s;

  rr_pick2 u_pick (
    .req0 (bus.req0),
    .req1 (bus.req1),
    .ptr  (ptr_q),
    .win  (pick_win),
    .any  (pick_any)
  );

  // Grants are forced low in a reset cycle even though the state register has not cleared yet.
  assign gnt0_s  = ~rst_f & (state_q == OWN0) & bus.req0;
  assign gnt1_s  = ~rst_f & (state_q == OWN1) & bus.req1;
  assign own_id  = (state_q == OWN1);
  assign own_req = own_id ? bus.req1 : bus.req0;
  assign oth_req = own_id ? bus.req0 : bus.req1;
  assign rd_fire = (gnt0_s & ~bus.we0) | (gnt1_s & ~bus.we1);

  // Owner FSM: burst_q only counts while the other port waits, so it stops at BURST_LAST.
  always_ff @(posedge clk) begin
    if (rst_f) begin
      state_q <= IDLE;
      burst_q <= '0;
      ptr_q   <= PORT_CPU;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_any) begin
            state_q <= pick_win ? OWN1 : OWN0;
            burst_q <= '0;
          end else begin
            state_q <= IDLE;
          end
        end
        OWN0, OWN1: begin
          if (own_req && !(oth_req && (burst_q == BURST_LAST))) begin
            if (oth_req) begin
              burst_q <= burst_q + BW'(1);
            end else begin
              burst_q <= burst_q;
            end
          end else begin
            burst_q <= '0;
            ptr_q   <= ~own_id;
            state_q <= oth_req ? (own_id ? OWN0 : OWN1) : IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
          burst_q <= '0;
        end
      endcase
    end
  end

  // Read return register: captures memory data on a read grant and pulses rvalid.
  always_ff @(posedge clk) begin
    if (rst_f) begin
      rvalid_q <= 1'b0;
      rid_q    <= PORT_CPU;
      rdata_q  <= '0;
    end else if (rd_fire) begin
      rvalid_q <= 1'b1;
      rid_q    <= gnt1_s ? PORT_LDR : PORT_CPU;
      rdata_q  <= bus.dm_rdata;
    end else begin
      rvalid_q <= 1'b0;
    end
  end

  // Memory-port mux from the current owner.
  always_comb begin
    dm_addr_s  = '0;
    dm_wdata_s = '0;
    if (!rst_f) begin
      case (state_q)
        OWN0: begin
          dm_addr_s  = bus.addr0;
          dm_wdata_s = bus.wdata0;
        end
        OWN1: begin
          dm_addr_s  = bus.addr1;
          dm_wdata_s = bus.wdata1;
        end
        default: begin
          dm_addr_s  = '0;
          dm_wdata_s = '0;
        end
      endcase
    end else begin
      dm_addr_s  = '0;
      dm_wdata_s = '0;
    end
  end

  assign bus.gnt0      = gnt0_s;
  assign bus.gnt1      = gnt1_s;
  assign bus.dm_we     = (gnt0_s & bus.we0) | (gnt1_s & bus.we1);
  assign bus.dm_addr   = dm_addr_s;
  assign bus.dm_wdata  = dm_wdata_s;
  assign bus.rvalid    = rvalid_q & ~rst_f;
  assign bus.rid       = rid_q & ~rst_f;
  assign bus.rdata     = rst_f ? '0 : rdata_q;
  assign bus.cpu_stall = bus.req0 & ~gnt0_s;
endmodule
